csa_accum_ctrl: RTL and testbench
=================================

Name: csa_accum_ctrl

Overview:
Sequencer that streams a convolution window wider than one adder pass through a single carry_save_adder instance. The window arrives as up to MAX_BEATS beats of N operands each. The block drives the adder one beat at a time, accumulates the partial sums, and presents the window total on a valid/ready output. It sits between the multiplier-array output and the activation stage of the CNN datapath.

Parameters:
N, 9, operands per beat (adder input count, N >= 3)
W, 8, operand width, unsigned
E, 4, adder bit extension; 2^E >= N required
MAX_BEATS, 3, maximum beats per window (>= 1)
ACC_W, W+E+1+$clog2(MAX_BEATS), accumulator / output width (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  beat present
in_ready  out  1  beat accepted when in_valid & in_ready
in_data  in  W*N  N operands; operand k = in_data[k*W +: W]
in_last  in  1  final beat of window
out_valid  out  1  window sum available
out_ready  in  1  consumer accepts sum
out_sum  out  ACC_W  window total
out_beats  out  $clog2(MAX_BEATS+1)  beats summed into out_sum
out_trunc  out  1  window closed by MAX_BEATS without in_last
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE; acc, beat_cnt, out_sum, out_beats, out_trunc = 0; out_valid=0; busy=0. Reset mid-window discards the partial sum with no output.
- Beat sum: in_data drives the adder combinationally. beat_sum = {cout,sum}, width W+E+1, zero-extended to ACC_W. All arithmetic is unsigned. ACC_W cannot overflow.
- States are IDLE, ACCUM and OUT.
- IDLE: in_ready=1. On accept: acc<=beat_sum, beat_cnt<=1.
  - If in_last or MAX_BEATS==1, go to OUT.
  - Otherwise go to ACCUM.
- ACCUM: in_ready=1. On accept: acc<=acc+beat_sum, beat_cnt<=beat_cnt+1.
  - If in_last or beat_cnt+1==MAX_BEATS, go to OUT.
  - No accept leaves acc and beat_cnt unchanged. in_valid may drop between beats.
- Entering OUT registers the results:
  - out_sum <= final acc value.
  - out_beats <= final beat count.
  - out_trunc <= (~in_last on the closing beat).
  - out_valid=1.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- OUT: out_sum, out_beats and out_trunc are held stable while out_valid=1 and out_ready=0. in_ready=out_ready.
  - out_ready=1 with no accepted beat: go to IDLE, out_valid=0.
  - out_ready=1 with an accepted beat (back-to-back): the beat starts a new window exactly as in IDLE (acc<=beat_sum, beat_cnt<=1).
    - Next state is OUT if that beat closes the window; out_valid stays 1 with the new results.
    - Otherwise next state is ACCUM.
- in_last on a beat that also hits MAX_BEATS gives out_trunc=0.
- No combinational path from in_valid to in_ready. The only combinational path out_ready->in_ready exists in OUT.

Decomposition:
- Package csa_ctrl_pkg holds:
  - The state enum (IDLE, ACCUM, OUT).
  - Function acc_width(W,E,MAX_BEATS).
  - Function cnt_width(MAX_BEATS).
- One sub-module: the existing carry_save_adder (#(.N(N),.E(E),.W(W))), instantiated unmodified. The rest is a single FSM/accumulator body.

Test Plan:
- All operands 0xFF; 3 beats, in_last on the 3rd -> 1 cycle later out_valid=1, out_sum=6885, out_beats=3, out_trunc=0.
- Single beat, operands 1..9, in_last=1 -> out_sum=45, out_beats=1. A 2-beat window (1..9 then 9x0x01, in_last) -> out_sum=54, out_beats=2.
- 3 beats of 9x0x10 with in_last never asserted -> out_sum=432, out_beats=3, out_trunc=1; the next beat starts a fresh window.
- Hold out_ready=0 for 5 cycles after a window -> out_sum and out_valid stable, in_ready=0, no beat consumed. Release with a new beat present -> that beat is accepted in the same cycle.
- Back-to-back single-beat windows with out_ready=1 and in_valid=1 continuously -> one result per cycle and out_valid never drops. Sums match the per-beat reference adder on 10^4 LFSR beats.
- Assert rst mid-window after 2 beats (async, between edges) -> outputs zero immediately. A following 1-beat window of 9x0x02 -> out_sum=18 (no residue).

Source files
------------

// File: rtl/csa_accum_ctrl_pkg.sv
// Shared types and width helpers for the carry-save window accumulator.
// Keeps the derived widths in one place so the top level and its interface always agree.
package csa_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    // One adder pass is W+E+1 bits; summing up to max_beats passes adds clog2(max_beats) bits.
    function automatic int acc_width(input int w, input int e, input int max_beats);
        return w + e + 1 + $clog2(max_beats);
    endfunction

    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Beat input / window-result output bundle for csa_accum_ctrl.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface csa_accum_ctrl_if
    import csa_ctrl_pkg::*;
#(
    parameter int N         = 9,
    parameter int W         = 8,
    parameter int E         = 4,
    parameter int MAX_BEATS = 3
);
    localparam int ACC_W = acc_width(W, E, MAX_BEATS);
    localparam int CNT_W = cnt_width(MAX_BEATS);

    logic             in_valid;
    logic             in_ready;
    logic [W*N-1:0]   in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_beats;
    logic             out_trunc;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_beats,
        output out_trunc,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_beats,
        input  out_trunc,
        input  busy
    );

endinterface

// File: rtl/csa_accum_ctrl_adder.sv
// N-operand unsigned adder: a linear chain of 3:2 compressors followed by one carry-propagate add.
// Result is {o_cout, o_sum}, W+E+1 bits; 2^E >= N keeps the true total inside W+E bits.
module carry_save_adder #(
    parameter int N = 9,
    parameter int E = 4,
    parameter int W = 8
) (
    input  logic [N*W-1:0] i_data,
    output logic [W+E-1:0] o_sum,
    output logic           o_cout
);
    localparam int WX = W + E + 1;

    logic [WX-1:0] w_op [N];
    logic [WX-1:0] w_s  [N-1];
    logic [WX-1:0] w_c  [N-1];
    logic [WX-1:0] w_total;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_op
            assign w_op[gi] = WX'(i_data[gi*W +: W]);
        end

        assign w_s[0] = w_op[0];
        assign w_c[0] = w_op[1];

        // s+c always equals the exact partial sum, which stays below 2^(WX-1),
        // so the carry shifted out of the top bit is always zero.
        for (gi = 1; gi < N - 1; gi++) begin : g_csa
            assign w_s[gi] = w_s[gi-1] ^ w_c[gi-1] ^ w_op[gi+1];
            assign w_c[gi] = ((w_s[gi-1] & w_c[gi-1]) |
                              (w_s[gi-1] & w_op[gi+1]) |
                              (w_c[gi-1] & w_op[gi+1])) << 1;
        end
    endgenerate

    assign w_total         = w_s[N-2] + w_c[N-2];
    assign {o_cout, o_sum} = w_total;

endmodule

// File: rtl/csa_accum_ctrl.sv
// Streams a multi-beat convolution window through one carry_save_adder, accumulates the
// per-beat sums and presents the window total on a valid/ready output.
module csa_accum_ctrl
    import csa_ctrl_pkg::*;
#(
    parameter int N         = 9,
    parameter int W         = 8,
    parameter int E         = 4,
    parameter int MAX_BEATS = 3
) (
    input  logic                clk,
    input  logic                rst,
    csa_accum_ctrl_if.slave     bus
);
    localparam int ACC_W = acc_width(W, E, MAX_BEATS);
    localparam int CNT_W = cnt_width(MAX_BEATS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_beats;
    logic             r_out_trunc;

    logic [W+E-1:0]   w_csa_sum;
    logic             w_csa_cout;
    logic [ACC_W-1:0] w_beat_sum;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_start;
    logic             w_close;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;

    carry_save_adder #(
        .N (N),
        .E (E),
        .W (W)
    ) u_csa (
        .i_data (bus.in_data),
        .o_sum  (w_csa_sum),
        .o_cout (w_csa_cout)
    );

    assign w_beat_sum = ACC_W'({w_csa_cout, w_csa_sum});

    // in_ready depends only on state and, while a result is held, on out_ready.
    assign w_in_ready = (r_state == OUT) ? bus.out_ready : 1'b1;
    assign w_accept   = bus.in_valid & w_in_ready;

    // A beat accepted outside ACCUM always opens a fresh window.
    assign w_start    = (r_state != ACCUM);
    assign w_acc_next = w_start ? w_beat_sum : (r_acc + w_beat_sum);
    assign w_cnt_next = w_start ? CNT_W'(1) : (r_beat_cnt + CNT_W'(1));
    assign w_close    = bus.in_last | (w_cnt_next == MAX_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, ACCUM: begin
                if (w_accept) begin
                    w_state_next = w_close ? OUT : ACCUM;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (w_accept) begin
                        w_state_next = w_close ? OUT : ACCUM;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_out_sum   <= '0;
            r_out_beats <= '0;
            r_out_trunc <= 1'b0;
        end else if (w_accept) begin
            r_acc      <= w_acc_next;
            r_beat_cnt <= w_cnt_next;
            if (w_close) begin
                r_out_sum   <= w_acc_next;
                r_out_beats <= w_cnt_next;
                r_out_trunc <= ~bus.in_last;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_sum   = r_out_sum;
    assign bus.out_beats = r_out_beats;
    assign bus.out_trunc = r_out_trunc;
    assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl: directed windows plus random traffic, all scored
// against a window-level model that sums operands with plain integer arithmetic.
module tb_csa_accum_ctrl;
    import csa_ctrl_pkg::*;

    localparam int N         = 9;
    localparam int W         = 8;
    localparam int E         = 4;
    localparam int MAX_BEATS = 3;

    typedef struct {
        longint unsigned sum;
        int              beats;
        bit              trunc;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    csa_accum_ctrl_if #(.N(N), .W(W), .E(E), .MAX_BEATS(MAX_BEATS)) bus ();

    csa_accum_ctrl #(.N(N), .W(W), .E(E), .MAX_BEATS(MAX_BEATS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              n_checks = 0;
    int              n_fail   = 0;
    bit              mon_en   = 1'b0;
    bit              verbose  = 1'b1;
    res_t            exp_q[$];
    longint unsigned m_sum    = 0;
    int              m_cnt    = 0;
    int              n_accepted = 0;
    longint unsigned last_sum   = 0;
    int              last_beats = 0;
    bit              last_trunc = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned beat_total(input logic [W*N-1:0] d);
        longint unsigned s = 0;
        for (int k = 0; k < N; k++) s += longint'(d[k*W +: W]);
        return s;
    endfunction

    function automatic logic [W*N-1:0] fill_const(input logic [W-1:0] v);
        logic [W*N-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = v;
        return d;
    endfunction

    function automatic logic [W*N-1:0] fill_seq();
        logic [W*N-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 1);
        return d;
    endfunction

    function automatic logic [W*N-1:0] fill_rand();
        logic [W*N-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    // Window-level reference: results pending consumption live in exp_q.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", bus.out_valid, exp_q.size() > 0);
            chk("in_ready", bus.in_ready, (exp_q.size() == 0) || bus.out_ready);
            chk("busy", bus.busy, (exp_q.size() > 0) || (m_cnt > 0));
            if (exp_q.size() > 0) begin
                chk("out_sum", bus.out_sum, exp_q[0].sum);
                chk("out_beats", bus.out_beats, exp_q[0].beats);
                chk("out_trunc", bus.out_trunc, exp_q[0].trunc);
                if (bus.out_ready) begin
                    last_sum   = exp_q[0].sum;
                    last_beats = exp_q[0].beats;
                    last_trunc = exp_q[0].trunc;
                    if (verbose)
                        $display("txn result sum=%0d beats=%0d trunc=%0d", last_sum, last_beats, last_trunc);
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                res_t r;
                n_accepted++;
                m_sum += beat_total(bus.in_data);
                m_cnt++;
                if (bus.in_last || m_cnt == MAX_BEATS) begin
                    r.sum   = m_sum;
                    r.beats = m_cnt;
                    r.trunc = !bus.in_last;
                    exp_q.push_back(r);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic send_beat(input logic [W*N-1:0] d, input logic last);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_sum"}, bus.out_sum, 0);
        chk({tag, "_out_beats"}, bus.out_beats, 0);
        chk({tag, "_out_trunc"}, bus.out_trunc, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_before;
        int drops;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        #2 rst = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Full-scale three-beat window.
        send_beat(fill_const(8'hFF), 1'b0);
        send_beat(fill_const(8'hFF), 1'b0);
        send_beat(fill_const(8'hFF), 1'b1);
        idle(1);
        chk("full_sum", last_sum, 6885);
        chk("full_beats", last_beats, 3);
        chk("full_trunc", last_trunc, 0);

        send_beat(fill_seq(), 1'b1);
        idle(1);
        chk("single_sum", last_sum, 45);
        chk("single_beats", last_beats, 1);

        send_beat(fill_seq(), 1'b0);
        send_beat(fill_const(8'h01), 1'b1);
        idle(1);
        chk("two_sum", last_sum, 54);
        chk("two_beats", last_beats, 2);

        // Window closed by the beat limit, then a fresh window.
        repeat (3) send_beat(fill_const(8'h10), 1'b0);
        idle(1);
        chk("trunc_sum", last_sum, 432);
        chk("trunc_beats", last_beats, 3);
        chk("trunc_flag", last_trunc, 1);
        send_beat(fill_const(8'h02), 1'b1);
        idle(1);
        chk("fresh_sum", last_sum, 18);
        chk("fresh_beats", last_beats, 1);
        chk("fresh_trunc", last_trunc, 0);

        // Backpressure: result held, waiting beat not consumed, then accepted on release.
        bus.out_ready = 1'b0;
        send_beat(fill_seq(), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = fill_const(8'h07);
        bus.in_last  = 1'b1;
        acc_before   = n_accepted;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("hold_no_accept", n_accepted, acc_before);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        chk("release_accept", n_accepted, acc_before + 1);
        chk("held_sum", last_sum, 45);
        idle(2);
        chk("after_hold_sum", last_sum, 63);

        // Back-to-back single-beat windows.
        verbose = 1'b0;
        drops = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            bus.in_data = fill_rand();
            @(negedge clk);
            if (i > 0 && !bus.out_valid) drops++;
            @(posedge clk);
            #1;
        end
        chk("b2b_drops", drops, 0);
        idle(2);

        // Random valid/last/ready mix.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_last   = ($urandom_range(0, 2) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data   = fill_rand();
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        bus.in_last   = 1'b0;
        idle(3);
        chk("random_drained", exp_q.size(), 0);

        // Finish any open window so the reset test starts from IDLE.
        if (m_cnt > 0) send_beat(fill_const(8'h00), 1'b1);
        idle(2);
        verbose = 1'b1;

        // Asynchronous reset after two beats of an open window.
        send_beat(fill_const(8'h33), 1'b0);
        send_beat(fill_const(8'h44), 1'b0);
        #2 rst = 1'b1;
        #1 check_zero_outputs("midrst");
        exp_q.delete();
        m_sum = 0;
        m_cnt = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        send_beat(fill_const(8'h02), 1'b1);
        idle(1);
        chk("post_rst_sum", last_sum, 18);
        chk("post_rst_beats", last_beats, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
